cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Host-side sequencer directly upstream of the CPU top level. It drives the CPU's `reset` and `start` inputs and consumes its `done` output.
- On a host request it resets the CPU, pulses `start`, and counts execution cycles until `done` rises or a timeout expires.
- It reports status (busy, finished, timed_out, cycle count) to the bench or host.

Parameters:
- RESET_CYCLES, 2, number of cycles `cpu_reset` is held high before start; legal range >= 1.
- CYCLE_W, 16, width of the cycle counter.
- MAX_CYCLES, 16'd50000, RUN-cycle budget before timeout; legal range 1 .. 2^CYCLE_W-1.

Ports:
- clk  in  1  single system clock, shared with the CPU.
- reset  in  1  synchronous, active-high controller reset.
- host_go  in  1  level or pulse; request a new program run.
- host_abort  in  1  pulse; cancel the current run and return to IDLE.
- cpu_done  in  1  the CPU top-level `done` output.
- cpu_reset  out  1  drives the CPU `reset`.
- cpu_start  out  1  drives the CPU `start`.
- busy  out  1  high while in RST, START or RUN.
- finished  out  1  high while in DONE.
- timed_out  out  1  high while in TIMEOUT.
- cycle_count  out  CYCLE_W  RUN cycles elapsed.

Behaviour:
- One clock. Reset is synchronous and active-high. The clock and reset ports are named `clk` and `reset`.
- States:
  - IDLE: cpu_reset=1, cpu_start=0.
  - RST: cpu_reset=1, cpu_start=0.
  - START: cpu_reset=0, cpu_start=1.
  - RUN: cpu_reset=0, cpu_start=0.
  - DONE: cpu_reset=0, cpu_start=0.
  - TIMEOUT: cpu_reset=0, cpu_start=0.
- All outputs are decoded from registered state and counters only. There is no combinational path from any input to any output.
- Reset values, applied at the first clk edge with reset=1:
  - state=IDLE, cpu_reset=1, cpu_start=0, busy=0, finished=0, timed_out=0, cycle_count=0.
  - The reset-cycle counter is also cleared.
- Transitions (priority order: reset > host_abort > others):
  - Any state, host_abort=1: next state IDLE; cycle_count cleared to 0.
  - IDLE, DONE or TIMEOUT, host_go=1: next state RST; cycle_count cleared to 0; reset-cycle counter loaded.
  - RST: stays exactly RESET_CYCLES cycles, then goes to START.
  - START: lasts exactly 1 cycle, then goes to RUN. cpu_done is ignored in START.
  - RUN, cpu_done=1: next state DONE. cycle_count does not increment in this cycle.
  - RUN, cpu_done=0:
    - If cycle_count+1 == MAX_CYCLES: cycle_count becomes MAX_CYCLES and the next state is TIMEOUT.
    - Otherwise cycle_count increments and the state stays RUN.
  - DONE and TIMEOUT: hold until host_go or host_abort. cycle_count holds its value.
- host_go is ignored in RST, START and RUN. No queuing of requests.
- cpu_reset is deasserted in DONE and TIMEOUT. The halted CPU stays frozen (PC held by its own done) so the bench can inspect memory.
- Latency and count semantics:
  - With host_go seen at edge k: cpu_reset is high through edge k+RESET_CYCLES, cpu_start is high for the one cycle after that, and RUN begins the cycle after START.
  - If cpu_done first samples high on the N-th RUN cycle, then cycle_count = N-1 and finished=1 from the next cycle.
- Same-cycle event rules:
  - cpu_done=1 on the cycle that would reach MAX_CYCLES: DONE wins over TIMEOUT.
  - host_abort together with host_go: abort wins; the state goes to IDLE.
- cycle_count never wraps; its maximum is MAX_CYCLES.

Test Plan:
- Reset, then host_go pulse; cpu_done rises on the 10th RUN cycle. Required:
  - cpu_reset high for exactly 2 cycles after go.
  - cpu_start high for exactly 1 cycle.
  - finished=1, cycle_count=9, busy=0, cpu_reset=0 afterwards.
- MAX_CYCLES=20, cpu_done held 0. Required: TIMEOUT reached with cycle_count=20, timed_out=1, finished=0, and the state stays there indefinitely.
- MAX_CYCLES=20, cpu_done=1 exactly on the cycle that would make the count 20. Required: finished=1, timed_out=0, cycle_count=19.
- host_abort on the 5th RUN cycle. Required: next cycle state IDLE, cpu_reset=1, busy=0, cycle_count=0. A host_go during the run is ignored.
- cpu_done held 1 during RST and START (stale from a previous run), then dropped on the first RUN cycle and raised later. Required: no early DONE; completion is counted only from the RUN-state sample.
- From DONE, host_go again. Required: a full new RST/START/RUN sequence with cycle_count restarting from 0. Synchronous reset asserted mid-RUN returns all outputs to their reset values at the next edge.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Host-side run sequencer for the CPU: resets it, pulses start, then counts
// RUN cycles until the CPU reports done or the cycle budget runs out.
module cpu_run_controller #(
    parameter int unsigned        RESET_CYCLES = 2,
    parameter int unsigned        CYCLE_W      = 16,
    parameter logic [CYCLE_W-1:0] MAX_CYCLES   = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_go,
    input  logic               host_abort,
    input  logic               cpu_done,
    output logic               cpu_reset,
    output logic               cpu_start,
    output logic               busy,
    output logic               finished,
    output logic               timed_out,
    output logic [CYCLE_W-1:0] cycle_count
);

    // Reset-cycle counter counts down from RESET_CYCLES-1 to 0 while in RST.
    localparam int unsigned    RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST     = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [RCW-1:0]     r_rst_cnt;
    logic [RCW-1:0]     w_rst_cnt_nxt;
    logic [CYCLE_W-1:0] r_count;
    logic [CYCLE_W-1:0] w_count_nxt;
    logic [CYCLE_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CYCLE_W'(1);

    // Next-state and counter update; abort overrides every other request.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_count_nxt   = r_count;
        if (host_abort) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (host_go) begin
                        w_state_nxt   = S_RST;
                        w_count_nxt   = '0;
                        w_rst_cnt_nxt = RST_LOAD;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == '0) begin
                        w_state_nxt = S_START;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt - RCW'(1);
                    end
                end
                S_START: begin
                    // cpu_done may still be stale from a previous run here
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    // done takes priority over reaching the budget
                    if (cpu_done) begin
                        w_state_nxt = S_DONE;
                    end else if (w_count_inc == MAX_CYCLES) begin
                        w_count_nxt = w_count_inc;
                        w_state_nxt = S_TIMEOUT;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Output decode from registered state only; no input reaches an output.
    always_comb begin
        cpu_reset = 1'b0;
        cpu_start = 1'b0;
        busy      = 1'b0;
        finished  = 1'b0;
        timed_out = 1'b0;
        case (r_state)
            S_IDLE:    cpu_reset = 1'b1;
            S_RST: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
            end
            S_START: begin
                cpu_start = 1'b1;
                busy      = 1'b1;
            end
            S_RUN:     busy      = 1'b1;
            S_DONE:    finished  = 1'b1;
            S_TIMEOUT: timed_out = 1'b1;
            default:   cpu_reset = 1'b1;
        endcase
    end

    assign cycle_count = r_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller using a time-since-go model.
module tb_cpu_run_controller;

    localparam int R   = 2;
    localparam int MAX = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_go;
    logic        host_abort;
    logic        cpu_done;
    logic        cpu_reset;
    logic        cpu_start;
    logic        busy;
    logic        finished;
    logic        timed_out;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: active run with t = cycles since go; ended = 0 idle, 1 done, 2 timeout
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_count  = 0;
    int m_ended  = 0;

    cpu_run_controller #(
        .RESET_CYCLES (R),
        .CYCLE_W      (16),
        .MAX_CYCLES   (16'd20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_go     (host_go),
        .host_abort  (host_abort),
        .cpu_done    (cpu_done),
        .cpu_reset   (cpu_reset),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit go, input bit abort, input bit done, input bit rst);
        if (rst || abort) begin
            m_active = 1'b0;
            m_ended  = 0;
            m_t      = 0;
            m_count  = 0;
        end else if (m_active) begin
            if (m_t <= R) begin
                m_t++;
            end else if (done) begin
                m_active = 1'b0;
                m_ended  = 1;
            end else begin
                m_count++;
                if (m_count == MAX) begin
                    m_active = 1'b0;
                    m_ended  = 2;
                end
            end
        end else if (go) begin
            m_active = 1'b1;
            m_t      = 0;
            m_count  = 0;
            m_ended  = 0;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_reset", cpu_reset, m_active ? int'(m_t < R) : int'(m_ended == 0));
            chk("cpu_start", cpu_start, int'(m_active && m_t == R));
            chk("busy", busy, int'(m_active));
            chk("finished", finished, int'(!m_active && m_ended == 1));
            chk("timed_out", timed_out, int'(!m_active && m_ended == 2));
            chk("cycle_count", int'(cycle_count), m_count);
        end
    end

    // Drive one cycle of inputs, take the edge, update the model, return at negedge
    task automatic step(input bit go, input bit abort, input bit done, input bit rst);
        host_go    = go;
        host_abort = abort;
        cpu_done   = done;
        reset      = rst;
        @(posedge clk);
        model_update(go, abort, done, rst);
        @(negedge clk);
    endtask

    // go pulse, then done on the n-th RUN cycle; optional stale done in RST/START
    task automatic run_prog(input int n, input bit stale, output int rst_hi, output int st_hi);
        rst_hi = 0;
        st_hi  = 0;
        step(1'b1, 1'b0, stale, 1'b0);
        rst_hi += int'(cpu_reset);
        st_hi  += int'(cpu_start);
        for (int i = 1; i <= 3 + n; i++) begin
            step(1'b0, 1'b0, (i == 3 + n) || (stale && i <= 3), 1'b0);
            rst_hi += int'(cpu_reset);
            st_hi  += int'(cpu_start);
        end
    endtask

    initial begin
        int rh;
        int sh;
        host_go    = 1'b0;
        host_abort = 1'b0;
        cpu_done   = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", int'(cycle_count), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic run: done on the 10th RUN cycle
        run_prog(10, 1'b0, rh, sh);
        chk("t1_reset_cycles", rh, 2);
        chk("t1_start_cycles", sh, 1);
        chk("t1_finished", finished, 1);
        chk("t1_count", int'(cycle_count), 9);
        chk("t1_busy", busy, 0);
        chk("t1_cpu_reset", cpu_reset, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Restart from DONE with stale done during RST/START
        run_prog(5, 1'b1, rh, sh);
        chk("t2_reset_cycles", rh, 2);
        chk("t2_finished", finished, 1);
        chk("t2_count", int'(cycle_count), 4);

        // Timeout with done held low
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3 + MAX; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_timed_out", timed_out, 1);
        chk("t3_count", int'(cycle_count), 20);
        chk("t3_finished", finished, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_hold_timed_out", timed_out, 1);
        chk("t3_hold_count", int'(cycle_count), 20);

        // done on the cycle that would reach the budget
        run_prog(MAX, 1'b0, rh, sh);
        chk("t4_finished", finished, 1);
        chk("t4_timed_out", timed_out, 0);
        chk("t4_count", int'(cycle_count), 19);

        // Abort on the 5th RUN cycle; go on the 2nd RUN cycle is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) step(i == 5, 1'b0, 1'b0, 1'b0);
        chk("t5_busy_pre", busy, 1);
        chk("t5_count_pre", int'(cycle_count), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_cpu_reset", cpu_reset, 1);
        chk("t5_busy", busy, 0);
        chk("t5_count", int'(cycle_count), 0);

        // Abort and go together: abort wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_busy", busy, 0);
        chk("t6_cpu_reset", cpu_reset, 1);

        // Synchronous reset mid-RUN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t7_count_pre", int'(cycle_count), 6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t7_cpu_reset", cpu_reset, 1);
        chk("t7_cpu_start", cpu_start, 0);
        chk("t7_busy", busy, 0);
        chk("t7_finished", finished, 0);
        chk("t7_timed_out", timed_out, 0);
        chk("t7_count", int'(cycle_count), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
